axi_to_core: RTL and testbench

Stream-to-core loader: an AXI-Stream slave that accepts a problem image from the host DMA and assembles it into one wide program register. It asserts `program_done` when the register is complete. It sits directly upstream of the core and of the result streamer `core_to_axi`, which waits on `program_done` and then `core_done`. It holds off the next frame until the core reports `core_done`, so the program register stays stable for the whole solve.

---
 rtl/cobi_stream_pkg.sv | 19 +
 rtl/program_assembler.sv | 39 +++
 rtl/axi_to_core.sv | 99 +++++++++
 tb/tb_axi_to_core.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cobi_stream_pkg.sv
// Shared types and sizing helpers for the COBI stream loader/streamer.
// Beat count and counter width are derived from the two stream widths.
package cobi_stream_pkg;

  typedef enum logic [1:0] {
    ST_RECV,
    ST_COMMIT,
    ST_WAIT
  } axi_to_core_state_t;

  function automatic int num_beats(input int dw, input int pw);
    return pw / dw;
  endfunction

  function automatic int beat_cnt_w(input int dw, input int pw);
    return $clog2(pw / dw);
  endfunction

endpackage

// File: rtl/program_assembler.sv
// Beat counter and assembly buffer for the program image.
// Beat k lands in slice k; clr wipes count and buffer.
module program_assembler
  import cobi_stream_pkg::*;
#(
  parameter int DATA_WIDTH_IN_STREAM = 32,
  parameter int PROGRAM_REG_SIZE     = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic                            clr,
  input  logic [DATA_WIDTH_IN_STREAM-1:0] data,
  output logic                            last_beat,
  output logic [PROGRAM_REG_SIZE-1:0]     buffer
);

  localparam int DW = DATA_WIDTH_IN_STREAM;
  localparam int NB = num_beats(DATA_WIDTH_IN_STREAM, PROGRAM_REG_SIZE);
  localparam int CW = beat_cnt_w(DATA_WIDTH_IN_STREAM, PROGRAM_REG_SIZE);

  logic [CW-1:0] cnt;

  assign last_beat = (cnt == CW'(NB - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      buffer <= '0;
    end else if (clr) begin
      cnt    <= '0;
      buffer <= '0;
    end else if (wr_en) begin
      buffer[cnt*DW +: DW] <= data;
      cnt <= last_beat ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axi_to_core.sv
// AXI-Stream loader: assembles beats into program_reg, then waits for core_done.
// Define AXI_TO_CORE_LAST_CHECK_EN to enable s_last framing checks (frame_err).
module axi_to_core
  import cobi_stream_pkg::*;
#(
  parameter int DATA_WIDTH_IN_STREAM = 32,
  parameter int PROGRAM_REG_SIZE     = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            s_last,
  input  logic [DATA_WIDTH_IN_STREAM-1:0] s_data,
  input  logic                            core_done,
  output logic [PROGRAM_REG_SIZE-1:0]     program_reg,
  output logic                            program_done,
  output logic                            frame_err
);

  localparam int DW = DATA_WIDTH_IN_STREAM;
  localparam int PW = PROGRAM_REG_SIZE;

  axi_to_core_state_t state;

  logic          hs;
  logic          frame_bad;
  logic          wr_en;
  logic          clr;
  logic          last_beat;
  logic [PW-1:0] buffer;
  logic [DW-1:0] unused_top;

  assign hs = s_valid & s_ready;

`ifdef AXI_TO_CORE_LAST_CHECK_EN
  assign frame_bad = s_last ^ last_beat;
`else
  logic unused_last;
  assign unused_last = s_last;
  assign frame_bad   = 1'b0;
`endif

  assign wr_en      = hs & ~frame_bad;
  assign clr        = hs & frame_bad;
  assign unused_top = buffer[PW-1 -: DW];

  program_assembler #(
    .DATA_WIDTH_IN_STREAM(DATA_WIDTH_IN_STREAM),
    .PROGRAM_REG_SIZE    (PROGRAM_REG_SIZE)
  ) u_asm (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .clr      (clr),
    .data     (s_data),
    .last_beat(last_beat),
    .buffer   (buffer)
  );

  // Final beat bypasses the buffer so the commit lands on the handshake edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RECV;
      s_ready      <= 1'b0;
      program_reg  <= '0;
      program_done <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      program_done <= 1'b0;
      frame_err    <= 1'b0;
      unique case (state)
        ST_RECV: begin
          s_ready   <= 1'b1;
          frame_err <= clr;
          if (wr_en && last_beat) begin
            program_reg  <= {s_data, buffer[PW-DW-1:0]};
            program_done <= 1'b1;
            s_ready      <= 1'b0;
            state        <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          s_ready <= 1'b0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          s_ready <= core_done;
          if (core_done) state <= ST_RECV;
        end
        default: begin
          s_ready <= 1'b0;
          state   <= ST_RECV;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_to_core.sv
// Directed self-checking bench for axi_to_core (32-bit beats, 128-bit image).
// Covers AXI_TO_CORE_LAST_CHECK_EN framing when that macro is defined.
module tb_axi_to_core;

  localparam int DW = 32;
  localparam int PW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [DW-1:0] s_data;
  logic          core_done;
  logic [PW-1:0] program_reg;
  logic          program_done;
  logic          frame_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_to_core #(
    .DATA_WIDTH_IN_STREAM(DW),
    .PROGRAM_REG_SIZE    (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_last      (s_last),
    .s_data      (s_data),
    .core_done   (core_done),
    .program_reg (program_reg),
    .program_done(program_done),
    .frame_err   (frame_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l, output int waited);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    waited  = 0;
    while (!s_ready && waited < 50) begin
      tick();
      waited++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout s_ready=%b required=1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 32'hBAD0_BAD0;
  endtask

  task automatic release_core();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready s_ready=%b required=1", s_ready);
    end
  endtask

  task automatic test_reset();
    s_valid   = 1'b0;
    s_last    = 1'b0;
    s_data    = '0;
    core_done = 1'b0;
    reset     = 1'b1;
    #2;
    checks++;
    if ({s_ready, program_done, frame_err} !== 3'b000 || program_reg !== '0) begin
      failures++;
      $display("FAIL reset_outputs rdy=%b done=%b err=%b reg=%h required all 0",
               s_ready, program_done, frame_err, program_reg);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset s_ready=%b required=1", s_ready);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [DW-1:0] beats [4];
    beats = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int i = 0; i < 4; i++) begin
      send_beat(beats[i], i == 3, w);
      checks++;
      if (w !== 0) begin
        failures++;
        $display("FAIL b2b_stall beat=%0d waited=%0d required=0", i, w);
      end
      if (i < 3) begin
        checks++;
        if (program_done !== 1'b0) begin
          failures++;
          $display("FAIL b2b_early_done beat=%0d done=%b required=0", i, program_done);
        end
      end
    end
    checks++;
    if (program_done !== 1'b1 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_commit done=%b rdy=%b required done=1 rdy=0",
               program_done, s_ready);
    end
    checks++;
    if (program_reg !== 128'h44444444_33333333_22222222_11111111) begin
      failures++;
      $display("FAIL b2b_reg got=%h required=44444444333333332222222211111111",
               program_reg);
    end
    tick();
    checks++;
    if (program_done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_width done=%b required=0", program_done);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (s_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_wait_ready cycle=%0d rdy=%b required=0", i, s_ready);
      end
      tick();
    end
  endtask

  task automatic test_core_wait();
    int w;
    logic bad_rdy;
    logic bad_reg;
    logic [DW-1:0] beats [4];
    beats   = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
    bad_rdy = 1'b0;
    bad_reg = 1'b0;
    s_valid = 1'b1;
    s_data  = beats[0];
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_ready !== 1'b0) bad_rdy = 1'b1;
      if (program_reg !== 128'h44444444_33333333_22222222_11111111) bad_reg = 1'b1;
    end
    checks++;
    if (bad_rdy) begin
      failures++;
      $display("FAIL hold_ready s_ready=1 seen required=0");
    end
    checks++;
    if (bad_reg) begin
      failures++;
      $display("FAIL hold_reg got=%h required=44444444333333332222222211111111",
               program_reg);
    end
    release_core();
    for (int i = 0; i < 4; i++) send_beat(beats[i], i == 3, w);
    checks++;
    if (program_done !== 1'b1 ||
        program_reg !== 128'hD0000004_C0000003_B0000002_A0000001) begin
      failures++;
      $display("FAIL frame2_commit done=%b got=%h required done=1 D0000004C0000003B0000002A0000001",
               program_done, program_reg);
    end
    tick();
  endtask

  task automatic test_valid_toggle();
    int w;
    logic [DW-1:0] beats [4];
    beats = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'hCAFEF00D};
    release_core();
    // core_done is held high through the frame and commit; it must be ignored
    core_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(beats[i], i == 3, w);
      if (i < 3) begin
        s_data = 32'hFFFF_0000;
        tick();
      end
    end
    checks++;
    if (program_done !== 1'b1 ||
        program_reg !== 128'hCAFEF00D_DEADBEEF_89ABCDEF_01234567) begin
      failures++;
      $display("FAIL toggle_commit done=%b got=%h required done=1 CAFEF00DDEADBEEF89ABCDEF01234567",
               program_done, program_reg);
    end
    tick();
    core_done = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL core_done_ignored rdy=%b required=0", s_ready);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    release_core();
    send_beat(32'hFFFFFFFF, 1'b0, w);
    send_beat(32'hEEEEEEEE, 1'b0, w);
    reset = 1'b1;
    #2;
    checks++;
    if ({s_ready, program_done, frame_err} !== 3'b000 || program_reg !== '0) begin
      failures++;
      $display("FAIL midreset_outputs rdy=%b done=%b err=%b reg=%h required all 0",
               s_ready, program_done, frame_err, program_reg);
    end
    tick();
    reset = 1'b0;
    send_beat(32'h00000005, 1'b0, w);
    send_beat(32'h00000006, 1'b0, w);
    send_beat(32'h00000007, 1'b0, w);
    send_beat(32'h00000008, 1'b1, w);
    checks++;
    if (program_done !== 1'b1 ||
        program_reg !== 128'h00000008_00000007_00000006_00000005) begin
      failures++;
      $display("FAIL midreset_commit done=%b got=%h required done=1 00000008000000070000000600000005",
               program_done, program_reg);
    end
    tick();
  endtask

`ifdef AXI_TO_CORE_LAST_CHECK_EN
  task automatic test_last_check();
    int w;
    release_core();
    send_beat(32'h12345678, 1'b0, w);
    send_beat(32'h9ABCDEF0, 1'b1, w);
    checks++;
    if (frame_err !== 1'b1 || program_done !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL early_last err=%b done=%b rdy=%b required err=1 done=0 rdy=1",
               frame_err, program_done, s_ready);
    end
    tick();
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL early_last_width err=%b required=0", frame_err);
    end
    for (int i = 0; i < 4; i++) send_beat(32'h77770000 + i, 1'b0, w);
    checks++;
    if (frame_err !== 1'b1 || program_done !== 1'b0 ||
        program_reg !== 128'h00000008_00000007_00000006_00000005) begin
      failures++;
      $display("FAIL missing_last err=%b done=%b reg=%h required err=1 done=0 unchanged",
               frame_err, program_done, program_reg);
    end
    for (int i = 0; i < 4; i++) send_beat(32'h55550000 + i, i == 3, w);
    checks++;
    if (program_done !== 1'b1 || frame_err !== 1'b0 ||
        program_reg !== 128'h55550003_55550002_55550001_55550000) begin
      failures++;
      $display("FAIL good_after_err done=%b err=%b got=%h required done=1 err=0 55550003555500025555000155550000",
               program_done, frame_err, program_reg);
    end
    tick();
  endtask
`else
  task automatic test_no_last();
    int w;
    logic err_seen;
    err_seen = 1'b0;
    release_core();
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h66660000 + i, 1'b0, w);
      if (frame_err !== 1'b0) err_seen = 1'b1;
    end
    checks++;
    if (program_done !== 1'b1 ||
        program_reg !== 128'h66660003_66660002_66660001_66660000) begin
      failures++;
      $display("FAIL no_last_commit done=%b got=%h required done=1 66660003666600026666000166660000",
               program_done, program_reg);
    end
    tick();
    if (frame_err !== 1'b0) err_seen = 1'b1;
    checks++;
    if (err_seen) begin
      failures++;
      $display("FAIL no_last_err frame_err=1 seen required=0");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_core_wait();
    test_valid_toggle();
    test_reset_mid();
`ifdef AXI_TO_CORE_LAST_CHECK_EN
    test_last_check();
`else
    test_no_last();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
